// File: rtl/gate_controller.sv
// gate_controller: car park entry/exit barrier controller.
//
// Two independent gate FSMs (index 0 = entry, 1 = exit) with states
// IDLE -> OPEN -> PASS -> REARM -> IDLE. Each request sensor feeds a
// saturating debounce counter. A request is valid in the cycle that the
// counter reaches DEBOUNCE_CYCLES. The entry gate refuses a valid request
// while parking_full is high. All outputs are registered.
//
// Optional feature: define GATE_TIMEOUT_EN to close a barrier that stays in
// OPEN for OPEN_TIMEOUT cycles without a car under it. No pulse is issued.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive high cycles for a valid request (1..15)
//   OPEN_TIMEOUT     open cycles allowed with no car (1..255, GATE_TIMEOUT_EN)
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   entry_req, entry_pass    entry presence / under-barrier sensors
//   exit_req, exit_pass      exit presence / under-barrier sensors
//   parking_full             no free spot remains
//   entry_open, exit_open    barrier open commands
//   car_in, car_out          one-cycle pulses on completed passages
//   entry_denied             one-cycle pulse on a refused entry request
module gate_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned OPEN_TIMEOUT    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic entry_req,
    input  logic entry_pass,
    input  logic exit_req,
    input  logic exit_pass,
    input  logic parking_full,
    output logic entry_open,
    output logic exit_open,
    output logic car_in,
    output logic car_out,
    output logic entry_denied
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StOpen  = 2'd1,
        StPass  = 2'd2,
        StRearm = 2'd3
    } gate_state_e;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..15");
    end
    if (OPEN_TIMEOUT < 1 || OPEN_TIMEOUT > 255) begin : g_bad_timeout
        $error("OPEN_TIMEOUT must be in 1..255");
    end

    localparam logic [3:0] DbFull = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] DbLast = 4'(DEBOUNCE_CYCLES - 1);

    logic [1:0]  w_req;
    logic [1:0]  w_pass;
    logic [1:0]  w_valid;
    logic [1:0]  w_done;
    logic [1:0]  w_open_d;
    gate_state_e w_state_d [2];
    logic [3:0]  w_db_d    [2];
    logic        w_denied_d;
    logic        w_car_in_d;
    logic        w_car_out_d;
    logic        w_in_pend_d;

    gate_state_e r_state [2];
    logic [3:0]  r_db    [2];
    logic [1:0]  r_open;
    logic        r_car_in;
    logic        r_car_out;
    logic        r_denied;
    logic        r_in_pend;

`ifdef GATE_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(OPEN_TIMEOUT - 1);
    logic [7:0] r_tmo   [2];
    logic [7:0] w_tmo_d [2];
`endif

    assign w_req  = {exit_req, entry_req};
    assign w_pass = {exit_pass, entry_pass};

    always_comb begin
        w_denied_d = 1'b0;
        for (int g = 0; g < 2; g++) begin
            // Saturating debounce: valid exactly once per continuous hold.
            w_db_d[g] = r_db[g];
            if (!w_req[g]) begin
                w_db_d[g] = '0;
            end else if (r_db[g] != DbFull) begin
                w_db_d[g] = r_db[g] + 4'd1;
            end
            w_valid[g] = w_req[g] && (r_db[g] == DbLast);

            w_state_d[g] = r_state[g];
            w_done[g]    = 1'b0;
`ifdef GATE_TIMEOUT_EN
            w_tmo_d[g]   = '0;
`endif
            unique case (r_state[g])
                StIdle: begin
                    if (w_valid[g]) begin
                        if (g == 0 && parking_full) begin
                            w_state_d[g] = StRearm;
                            w_denied_d   = 1'b1;
                        end else begin
                            w_state_d[g] = StOpen;
                        end
                    end
                end
                StOpen: begin
                    if (w_pass[g]) begin
                        w_state_d[g] = StPass;
`ifdef GATE_TIMEOUT_EN
                    end else if (r_tmo[g] == TmoLast) begin
                        w_state_d[g] = StRearm;
                    end else begin
                        w_tmo_d[g] = r_tmo[g] + 8'd1;
`endif
                    end
                end
                StPass: begin
                    if (!w_pass[g]) begin
                        w_state_d[g] = StRearm;
                        w_done[g]    = 1'b1;
                    end
                end
                StRearm: begin
                    // Counter at 0 means the sensor was low last cycle too.
                    if (!w_req[g] && r_db[g] == 4'd0) begin
                        w_state_d[g] = StIdle;
                    end
                end
                default: w_state_d[g] = StIdle;
            endcase
            w_open_d[g] = (w_state_d[g] == StOpen) || (w_state_d[g] == StPass);
        end

        // car_out wins a collision; car_in is held back one cycle.
        w_car_out_d = w_done[1];
        w_car_in_d  = !w_done[1] && (r_in_pend || w_done[0]);
        w_in_pend_d = w_done[1] && (r_in_pend || w_done[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 2; g++) begin
                r_state[g] <= StIdle;
                r_db[g]    <= '0;
`ifdef GATE_TIMEOUT_EN
                r_tmo[g]   <= '0;
`endif
            end
            r_open    <= '0;
            r_car_in  <= 1'b0;
            r_car_out <= 1'b0;
            r_denied  <= 1'b0;
            r_in_pend <= 1'b0;
        end else begin
            for (int g = 0; g < 2; g++) begin
                r_state[g] <= w_state_d[g];
                r_db[g]    <= w_db_d[g];
`ifdef GATE_TIMEOUT_EN
                r_tmo[g]   <= w_tmo_d[g];
`endif
            end
            r_open    <= w_open_d;
            r_car_in  <= w_car_in_d;
            r_car_out <= w_car_out_d;
            r_denied  <= w_denied_d;
            r_in_pend <= w_in_pend_d;
        end
    end

    assign entry_open   = r_open[0];
    assign exit_open    = r_open[1];
    assign car_in       = r_car_in;
    assign car_out      = r_car_out;
    assign entry_denied = r_denied;

endmodule

// File: doc/gate_controller.md
GATE_CONTROLLER -- requirements
Module: gate_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive high cycles a request sensor must hold to count as a request (range 1..15).
REQ-002 SHALL have parameter OPEN_TIMEOUT, default 16: cycles a barrier may stay open with no car detected (range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port entry_req, input, 1 bit: car presence sensor in front of the entry barrier.
REQ-006 SHALL have port entry_pass, input, 1 bit: car-under-barrier sensor at the entry gate.
REQ-007 SHALL have port exit_req, input, 1 bit: car presence sensor in front of the exit barrier.
REQ-008 SHALL have port exit_pass, input, 1 bit: car-under-barrier sensor at the exit gate.
REQ-009 SHALL have port parking_full, input, 1 bit: high when no free spot remains.
REQ-010 SHALL have port entry_open, output, 1 bit: entry barrier open command.
REQ-011 SHALL have port exit_open, output, 1 bit: exit barrier open command.
REQ-012 SHALL have port car_in, output, 1 bit: one-cycle pulse when a car has fully entered.
REQ-013 SHALL have port car_out, output, 1 bit: one-cycle pulse when a car has fully exited.
REQ-014 SHALL have port entry_denied, output, 1 bit: one-cycle pulse when an entry request is refused because the car park is full.

Function
REQ-015 The entry and exit gates SHALL each be controlled by an independent FSM with states IDLE, OPEN, PASS, REARM; all outputs SHALL be registered.
REQ-016 Each request sensor SHALL have a saturating debounce counter. The counter increments while the sensor is high and clears to 0 whenever the sensor is low. A request is valid in the cycle the counter reaches DEBOUNCE_CYCLES.
REQ-017 Entry FSM in IDLE on a valid request: if parking_full=0, go to OPEN; if parking_full=1, pulse entry_denied for one cycle and go to REARM.
REQ-018 Exit FSM in IDLE on a valid request: go to OPEN. parking_full SHALL be ignored for the exit gate.
REQ-019 The *_open output SHALL be 1 in OPEN and PASS, and 0 in IDLE and REARM. It rises one cycle after the valid request.
REQ-020 OPEN to PASS SHALL happen on the first cycle the pass sensor is high. PASS to REARM SHALL happen on the first cycle the pass sensor is low, and that transition SHALL produce a car_in or car_out pulse on the following cycle.
REQ-021 REARM to IDLE SHALL happen only when the request sensor is low and the debounce counter is 0, so one held sensor yields at most one request.
REQ-022 If car_in and car_out are due in the same cycle, car_out SHALL be issued first and car_in delayed exactly one cycle; no pulse is ever lost and the two never overlap.
REQ-023 The parking_full value sampled in the IDLE decision cycle SHALL be the one that applies; changes to parking_full while the barrier is open SHALL not close it.

Reset
REQ-024 While rst=1, both FSMs SHALL be in IDLE, all counters 0, and all outputs 0 (barriers closed, no pulses), regardless of clk.
REQ-025 Reset asserted mid-passage SHALL close the barrier immediately and discard any pending or deferred car_in/car_out pulse.
REQ-026 After rst deasserts, a sensor still held high SHALL need a full DEBOUNCE_CYCLES count before it is accepted as a request.

Configuration
REQ-027 With macro GATE_TIMEOUT_EN defined, each FSM in OPEN SHALL count cycles; if the pass sensor is still low after OPEN_TIMEOUT cycles, the FSM SHALL go to REARM with no car_in/car_out pulse.
REQ-028 Without GATE_TIMEOUT_EN, OPEN SHALL have no timeout, the timeout counters SHALL be absent, and the barrier stays open until the pass sensor goes high.

Verification
REQ-029 Entry, not full: entry_req high 4 cycles -> entry_open=1 on the next cycle; entry_pass high 3 cycles then low -> car_in pulses once, entry_open=0.
REQ-030 Full: parking_full=1, entry_req held 10 cycles -> a single entry_denied pulse, entry_open stays 0, no car_in.
REQ-031 Glitch: entry_req high 3 cycles then low -> no open, no pulse; exit_req held 50 cycles with one passage -> exactly one car_out.
REQ-032 Simultaneous: entry_pass and exit_pass fall in the same cycle -> car_out on cycle N, car_in on cycle N+1.
REQ-033 Timeout (GATE_TIMEOUT_EN defined): exit opened, exit_pass never high -> exit_open=0 after 16 cycles, no car_out; without the macro -> exit_open stays 1.
REQ-034 Reset during PASS: rst pulse -> entry_open=0 immediately, no car_in after release.
